// File: rtl/uart_rx_fifo_if.sv
// Receive-side pop interface of the UART receiver: FIFO head, occupancy,
// sticky error flags and the consumer's pop/clear strobes.
interface uart_rx_fifo_if #(
    parameter int unsigned fifo_depth = 4
);
    logic [7:0]                    o_data;
    logic                          o_valid;
    logic                          i_rd;
    logic [$clog2(fifo_depth):0]   o_count;
    logic                          o_overrun;
    logic                          o_frame_err;
    logic                          i_clr_err;

    // Consumer side (CPU / IO decoder)
    modport master (
        input  o_data, o_valid, o_count, o_overrun, o_frame_err,
        output i_rd, i_clr_err
    );

    // Receiver side
    modport slave (
        output o_data, o_valid, o_count, o_overrun, o_frame_err,
        input  i_rd, i_clr_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through receive FIFO,
// with sticky overrun and framing-error flags.
module uart_rx_fifo #(
    parameter int unsigned clk_freq_hz = 25000000,
    parameter int unsigned baud_rate   = 115200,
    parameter int unsigned fifo_depth  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx,
    uart_rx_fifo_if.slave rx_if
);
    localparam int unsigned DIV  = clk_freq_hz / baud_rate;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV + 1);
    localparam int unsigned PW   = $clog2(fifo_depth);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [PW:0]   DEPTH   = (PW + 1)'(fifo_depth);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          rx_prev_q, rx_prev_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [fifo_depth];
    logic [7:0]    mem_d [fifo_depth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;

    logic rx_s;
    logic push;
    logic frame_bad;
    logic pop;
    logic full;
    logic wr_en;

    assign rx_s = sync2_q;

    // State register: every flop of the block, synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state: synchroniser, edge history, bit timing and deserialisation
    always_comb begin
        sync1_d   = i_rx;
        sync2_d   = sync1_q;
        rx_prev_d = rx_s;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        unique case (state_q)
            S_IDLE: begin
                // Falling edge only: a held-low line (break) cannot retrigger
                if (rx_prev_q && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        cnt_d   = DIV_M1;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = DIV_M1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and the externally visible FIFO head/status
    always_comb begin
        push              = (state_q == S_STOP) && (cnt_q == '0) && rx_s;
        frame_bad         = (state_q == S_STOP) && (cnt_q == '0) && !rx_s;
        rx_if.o_data      = mem_q[rd_ptr_q];
        rx_if.o_valid     = (count_q != '0);
        rx_if.o_count     = count_q;
        rx_if.o_overrun   = overrun_q;
        rx_if.o_frame_err = frame_err_q;
    end

    // FIFO bookkeeping and sticky error flags (a new event beats a clear)
    always_comb begin
        pop      = rx_if.i_rd && (count_q != '0);
        full     = (count_q == DEPTH);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en    = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (PW + 1)'(1);
        end
        if (push && !wr_en) begin
            overrun_d = 1'b1;
        end else if (rx_if.i_clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end else if (rx_if.i_clr_err) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end
endmodule
